pwm_multi_channel_ctrl: RTL and testbench
=========================================

Name: pwm_multi_channel_ctrl

Overview:
Parametrised successor to the single-channel button/PWM/7-seg datapath. Holds CHANNELS independent duty levels, each in 0..MAX_LEVEL. Two shared buttons raise or lower the level of the channel picked by sel_i, and every channel drives its own PWM output from one shared phase counter. The level of the selected channel is exported so the existing 7-seg driver can display it; the block replaces the counter plus PWM pair inside the TT top.

Parameters:
CHANNELS, 4, number of independent PWM channels (1..16)
MAX_LEVEL, 9, highest duty level; level L gives duty L/MAX_LEVEL (2..255)
PRESCALE, 256, clock cycles per phase step; PWM period = MAX_LEVEL*PRESCALE cycles (>=1)
WRAP, 0, 0 = saturate at 0/MAX_LEVEL; 1 = wrap MAX_LEVEL<->0
FADE_CYCLES, 1024, clock cycles per fade step; used only with PWM_MC_FADE_EN (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
incr_i  in  1  increase button, asynchronous, level
decr_i  in  1  decrease button, asynchronous, level
sel_i  in  SW=max(1,$clog2(CHANNELS))  channel selected for button action and level_o
level_o  out  LW=$clog2(MAX_LEVEL+1)  target level of selected channel
pwm_o  out  CHANNELS  PWM output per channel, registered

Behaviour:
- One clock; reset is asynchronous and active-low (rst_ni). While rst_ni=0: all levels 0, synchronisers 0, prescaler 0, phase 0, pwm_o=0, level_o=0.
- Button path: 2-flop synchroniser plus 1 history flop per button. Event = synced & ~history (rising edge only). Holding a button gives exactly one event.
- Latency: incr_i first sampled high at edge E0 -> target level updated at E2, visible on level_o after E2.
- Update at event edge: sel_i sampled at that same edge (not synchronised). Only target[sel_i] changes.
- incr event: L<MAX_LEVEL -> L+1; L=MAX_LEVEL -> stays (WRAP=0) or 0 (WRAP=1).
- decr event: L>0 -> L-1; L=0 -> stays (WRAP=0) or MAX_LEVEL (WRAP=1).
- incr and decr events in the same cycle: no change.
- sel_i >= CHANNELS (non-power-of-2 CHANNELS): events ignored, level_o=0.
- level_o is combinational from target[sel_i]; it follows sel_i changes in the same cycle.
- Prescaler counts 0..PRESCALE-1. Phase counts 0..MAX_LEVEL-1 and advances when the prescaler is at PRESCALE-1. Both wrap to 0.
- pwm_o[c] <= (phase < eff[c]), registered, 1-cycle latency. eff=0 -> constant 0; eff=MAX_LEVEL -> constant 1.
- All channels share the phase counter, so their rising edges are aligned at phase 0.
- Without the fade feature, eff[c] = target[c].
- An asynchronous reset mid-period clears pwm_o immediately. After release, the counters restart from 0.

Optional Feature:
PWM_MC_FADE_EN defined:
- Each channel has an effective-level register eff[c] plus a shared fade tick counter (0..FADE_CYCLES-1).
- On each tick wrap, every eff[c] != target[c] moves one step toward target[c]. Movement is linear and never wraps, even with WRAP=1.
- Reset clears eff to 0.
- level_o still reports the target level.
Not defined: no fade counter and no eff registers. eff = target, so a level change reaches pwm_o at the next phase comparison.

Test Plan:
Common parameters: CHANNELS=4, MAX_LEVEL=9, PRESCALE=2, WRAP=0, FADE_CYCLES=4.
1. Reset: pulse rst_ni low mid-cycle -> pwm_o=4'b0000 and level_o=0 immediately; both stay 0 for 100 cycles after release with no buttons.
2. sel_i=0, incr_i held high for 6 cycles -> level_o 0->1 exactly 2 edges after first sample and no further change. pwm_o[0] is high 2 of every 18 cycles; other bits stay 0.
3. sel_i=1, 12 separate incr pulses -> level_o saturates at 9 and pwm_o[1] is constant 1. With WRAP=1, the 10th pulse gives 0, and a decr pulse at 0 gives 9.
4. Channel 2 at level 4: incr_i and decr_i rise on the same edge -> level stays 4. A decr pulse alone -> 3.
5. Set channel 2 to 3 and channel 0 to 5, then toggle sel_i -> level_o shows 3/5 in the same cycle. pwm_o[2] is high 6/18 cycles and pwm_o[0] high 10/18, with rising edges coincident.
6. PWM_MC_FADE_EN defined, channel 3 stepped 0->4 -> level_o=4 at once. eff steps 1,2,3,4 at 4-cycle intervals, and pwm_o[3] duty grows accordingly.

Source files
------------

// File: rtl/pwm_multi_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multi_channel_ctrl
// Description : Multi-channel button-controlled PWM generator. Holds CHANNELS
//               duty levels (0..MAX_LEVEL). Two shared buttons step the level
//               of the channel chosen by sel_i. Each channel drives its own
//               PWM output from one shared phase counter.
//               Optional macro PWM_MC_FADE_EN: the PWM follows a per-channel
//               effective level that ramps toward the target one step per
//               fade tick.
// Ports       : clk_i   - clock
//               rst_ni  - asynchronous active-low reset
//               incr_i  - increase button (asynchronous level)
//               decr_i  - decrease button (asynchronous level)
//               sel_i   - channel selected for button action and level_o
//               level_o - target level of the selected channel (combinational)
//               pwm_o   - registered PWM output per channel
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_channel_ctrl #(
    parameter int CHANNELS    = 4,
    parameter int MAX_LEVEL   = 9,
    parameter int PRESCALE    = 256,
    parameter int WRAP        = 0,
    parameter int FADE_CYCLES = 1024,
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LW = $clog2(MAX_LEVEL + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                incr_i,
    input  logic                decr_i,
    input  logic [SW-1:0]       sel_i,
    output logic [LW-1:0]       level_o,
    output logic [CHANNELS-1:0] pwm_o
);

    localparam int            c_pw         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pw-1:0] c_presc_last = c_pw'(PRESCALE - 1);
    localparam logic [LW-1:0] c_max        = LW'(MAX_LEVEL);
    localparam logic [LW-1:0] c_phase_last = LW'(MAX_LEVEL - 1);

    // Elaboration-time guard against unsupported parameter values.
    if (CHANNELS < 1 || CHANNELS > 16 || MAX_LEVEL < 2 || MAX_LEVEL > 255 ||
        PRESCALE < 1 || FADE_CYCLES < 1) begin : g_param_check
        $error("pwm_multi_channel_ctrl: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Button synchronisers: two flops for metastability plus one history
    // flop so a held button yields a single rising-edge event.
    // ------------------------------------------------------------------
    logic r_incr_meta, r_incr_sync, r_incr_hist;
    logic r_decr_meta, r_decr_sync, r_decr_hist;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_incr_meta <= 1'b0;
            r_incr_sync <= 1'b0;
            r_incr_hist <= 1'b0;
            r_decr_meta <= 1'b0;
            r_decr_sync <= 1'b0;
            r_decr_hist <= 1'b0;
        end else begin
            r_incr_meta <= incr_i;
            r_incr_sync <= r_incr_meta;
            r_incr_hist <= r_incr_sync;
            r_decr_meta <= decr_i;
            r_decr_sync <= r_decr_meta;
            r_decr_hist <= r_decr_sync;
        end
    end

    logic w_incr_ev, w_decr_ev;
    assign w_incr_ev = r_incr_sync & ~r_incr_hist;
    assign w_decr_ev = r_decr_sync & ~r_decr_hist;

    // ------------------------------------------------------------------
    // Target levels. sel_i is used unsynchronised; an out-of-range select
    // hits no channel, so events are dropped and level_o reads 0.
    // ------------------------------------------------------------------
    logic [LW-1:0]       r_target [CHANNELS];
    logic [CHANNELS-1:0] w_hit;
    logic [LW-1:0]       w_level;
    logic [LW-1:0]       w_next;

    always_comb begin
        w_hit   = '0;
        w_level = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_i == SW'(c)) begin
                w_hit[c] = 1'b1;
                w_level  = r_target[c];
            end
        end
    end

    always_comb begin
        w_next = w_level;
        if (w_incr_ev) begin
            if (w_level == c_max) w_next = (WRAP != 0) ? '0 : c_max;
            else                  w_next = w_level + 1'b1;
        end else if (w_decr_ev) begin
            if (w_level == '0)    w_next = (WRAP != 0) ? c_max : '0;
            else                  w_next = w_level - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < CHANNELS; c++) r_target[c] <= '0;
        end else if (w_incr_ev ^ w_decr_ev) begin
            // Simultaneous incr and decr events cancel out.
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_hit[c]) r_target[c] <= w_next;
            end
        end
    end

    assign level_o = w_level;

    // ------------------------------------------------------------------
    // Shared prescaler and phase counter.
    // ------------------------------------------------------------------
    logic [c_pw-1:0] r_presc;
    logic [LW-1:0]   r_phase;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_presc <= '0;
            r_phase <= '0;
        end else if (r_presc == c_presc_last) begin
            r_presc <= '0;
            r_phase <= (r_phase == c_phase_last) ? '0 : r_phase + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Effective level driving the comparator.
    // ------------------------------------------------------------------
    logic [LW-1:0] w_eff [CHANNELS];

`ifdef PWM_MC_FADE_EN
    localparam int              c_fw        = (FADE_CYCLES > 1) ? $clog2(FADE_CYCLES) : 1;
    localparam logic [c_fw-1:0] c_fade_last = c_fw'(FADE_CYCLES - 1);

    logic [c_fw-1:0] r_fade_cnt;
    logic [LW-1:0]   r_eff [CHANNELS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fade_cnt <= '0;
            for (int c = 0; c < CHANNELS; c++) r_eff[c] <= '0;
        end else if (r_fade_cnt == c_fade_last) begin
            r_fade_cnt <= '0;
            // Linear ramp; never wraps regardless of WRAP.
            for (int c = 0; c < CHANNELS; c++) begin
                if (r_eff[c] < r_target[c])      r_eff[c] <= r_eff[c] + 1'b1;
                else if (r_eff[c] > r_target[c]) r_eff[c] <= r_eff[c] - 1'b1;
            end
        end else begin
            r_fade_cnt <= r_fade_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) w_eff[c] = r_eff[c];
    end
`else
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) w_eff[c] = r_target[c];
    end
`endif

    // ------------------------------------------------------------------
    // PWM comparators. Phase never reaches MAX_LEVEL, so eff=MAX_LEVEL
    // gives a constant 1 and eff=0 a constant 0.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] r_pwm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pwm <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) r_pwm[c] <= (r_phase < w_eff[c]);
        end
    end

    assign pwm_o = r_pwm;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_multi_channel_ctrl
// Description : Self-checking bench for pwm_multi_channel_ctrl. A saturating
//               instance and a wrapping instance share the select input and
//               have their own buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_channel_ctrl;

    localparam int CH     = 4;
    localparam int ML     = 9;
    localparam int PS     = 2;
    localparam int FC     = 4;
    localparam int PERIOD = ML * PS;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       incr  = 1'b0;
    logic       decr  = 1'b0;
    logic       wincr = 1'b0;
    logic       wdecr = 1'b0;
    logic [1:0] sel   = 2'd0;
    logic [3:0] lvl, wlvl;
    logic [3:0] pwm, wpwm;

    always #5 clk = ~clk;

    pwm_multi_channel_ctrl #(
        .CHANNELS(CH), .MAX_LEVEL(ML), .PRESCALE(PS), .WRAP(0), .FADE_CYCLES(FC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .incr_i(incr), .decr_i(decr),
        .sel_i(sel), .level_o(lvl), .pwm_o(pwm)
    );

    pwm_multi_channel_ctrl #(
        .CHANNELS(CH), .MAX_LEVEL(ML), .PRESCALE(PS), .WRAP(1), .FADE_CYCLES(FC)
    ) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .incr_i(wincr), .decr_i(wdecr),
        .sel_i(sel), .level_o(wlvl), .pwm_o(wpwm)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] sel;
        bit         inc;
        bit         dec;
        int         exp_level;
        bit         duty;
    } vec_t;

    vec_t vecs[$];
    int   exp_q[$];
    int   exp_lv[CH];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int s, input bit i, input bit d, input int e, input bit du);
        vec_t v;
        v.sel = 2'(s); v.inc = i; v.dec = d; v.exp_level = e; v.duty = du;
        vecs.push_back(v);
    endfunction

    // One button pulse: held 3 edges (past the update edge), then 3 low edges
    // so the history flop clears before the next pulse.
    task automatic press(input bit w, input int s, input bit i, input bit d);
        @(negedge clk);
        sel = 2'(s);
        if (w) begin wincr = i; wdecr = d; end
        else   begin incr  = i; decr  = d; end
        repeat (3) @(negedge clk);
        incr = 1'b0; decr = 1'b0; wincr = 1'b0; wdecr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // High-cycle count over one full period per channel: 2*level with PRESCALE=2.
    task automatic duty_check(input string tag);
        int cnt[CH];
        repeat (8) @(negedge clk);
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (pwm[c]) cnt[c]++;
        end
        for (int c = 0; c < CH; c++)
            check($sformatf("%s_duty_ch%0d", tag, c), cnt[c], PS * exp_lv[c]);
    endtask

    initial begin
        int got;
        int r0, r2, nz_pwm, nz_lvl;
        logic [3:0] prev;

        for (int c = 0; c < CH; c++) exp_lv[c] = 0;

        // Vector table: {sel, incr, decr, expected level, check duty}
        for (int i = 1; i <= 12; i++) add(1, 1, 0, (i < ML) ? i : ML, i == 12);
        for (int i = 1; i <= 4; i++)  add(2, 1, 0, i, 0);
        add(2, 1, 1, 4, 0);
        add(2, 0, 1, 3, 0);
        for (int i = 2; i <= 5; i++)  add(0, 1, 0, i, i == 5);
        add(3, 0, 1, 0, 0);
        add(3, 1, 0, 1, 0);
        add(3, 0, 1, 0, 1);
        add(1, 0, 1, 8, 0);
        add(1, 1, 0, 9, 1);

        // Reset state
        #2;
        check("reset_pwm", int'(pwm), 0);
        check("reset_level", int'(lvl), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Held button: one step, exactly two edges after first sample
        sel = 2'd0; incr = 1'b1;
        @(negedge clk); check("lat_e0", int'(lvl), 0);
        @(negedge clk); check("lat_e1", int'(lvl), 0);
        @(negedge clk); check("lat_e2", int'(lvl), 1);
        repeat (3) @(negedge clk);
        incr = 1'b0;
        repeat (6) @(negedge clk);
        check("held_single_step", int'(lvl), 1);
        exp_lv[0] = 1;
        duty_check("held");

        // Table-driven pulses with scoreboard
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp_level);
            press(1'b0, int'(vecs[i].sel), vecs[i].inc, vecs[i].dec);
            got = exp_q.pop_front();
            check($sformatf("vec%0d_level", i), int'(lvl), got);
            exp_lv[vecs[i].sel] = got;
            if (vecs[i].duty) duty_check($sformatf("vec%0d", i));
        end

        // level_o follows sel_i in the same cycle
        @(negedge clk);
        sel = 2'd2; #1 check("sel2_level", int'(lvl), 3);
        sel = 2'd0; #1 check("sel0_level", int'(lvl), 5);
        sel = 2'd1; #1 check("sel1_level", int'(lvl), 9);
        sel = 2'd3; #1 check("sel3_level", int'(lvl), 0);

        // Rising edges of channels 0 and 2 coincide
        r0 = -1; r2 = -1;
        @(negedge clk); prev = pwm;
        for (int k = 0; k < 2 * PERIOD; k++) begin
            @(negedge clk);
            if (r0 < 0 && pwm[0] && !prev[0]) r0 = k;
            if (r2 < 0 && pwm[2] && !prev[2]) r2 = k;
            prev = pwm;
        end
        check("rise_seen", int'(r0 >= 0), 1);
        check("rise_align", r2, r0);

        // Wrapping instance: 9 -> 0 on incr, 0 -> 9 on decr
        for (int i = 1; i <= 10; i++) begin
            press(1'b1, 1, 1'b1, 1'b0);
            if (i == 9)  check("wrap_up9", int'(wlvl), 9);
            if (i == 10) check("wrap_up10", int'(wlvl), 0);
        end
        press(1'b1, 1, 1'b0, 1'b1);
        check("wrap_dn0", int'(wlvl), 9);

`ifdef PWM_MC_FADE_EN
        // Fade: target jumps immediately, PWM duty settles to the target
        for (int i = 1; i <= 4; i++) begin
            press(1'b0, 3, 1'b1, 1'b0);
            check($sformatf("fade_level%0d", i), int'(lvl), i);
        end
        exp_lv[3] = 4;
        repeat (8 * FC) @(negedge clk);
        duty_check("fade");
`endif

        // Asynchronous reset mid-period
        sel = 2'd1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midreset_pwm", int'(pwm), 0);
        check("midreset_level", int'(lvl), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nz_pwm = 0; nz_lvl = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pwm != 4'd0) nz_pwm++;
            if (lvl != 4'd0) nz_lvl++;
        end
        check("post_reset_pwm_idle", nz_pwm, 0);
        check("post_reset_level_idle", nz_lvl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
